// File: rtl/ads7843_pkg.sv
// ads7843_pkg: shared types and constants for the ADS7843 SPI controller.
//   - state_e     : conversion FSM states
//   - ADDR_*      : Avalon register indices
//   - STAT_*/IRQ_*: bit positions inside the status and IRQ registers
//   - DOUT_*      : rising-edge window (1-based) in which DOUT carries the result
package ads7843_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_e;

  localparam logic [1:0] ADDR_CMD  = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_DATA = 2'd2;
  localparam logic [1:0] ADDR_IRQ  = 2'd3;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_BUSY_SYNC = 2;

  localparam int unsigned IRQ_EN_BIT  = 0;
  localparam int unsigned IRQ_PEN_BIT = 1;

  localparam int unsigned DOUT_FIRST = 10;
  localparam int unsigned DOUT_LAST  = 21;

  // True when rising edge n (1-based) falls inside the 12-bit result window.
  function automatic logic in_dout_window(input logic [4:0] n);
    return (n >= 5'(DOUT_FIRST)) && (n <= 5'(DOUT_LAST));
  endfunction

endpackage

// File: rtl/ads_clk_div.sv
// ads_clk_div: DCLK half-period tick generator.
//   clk, reset_n : system clock, asynchronous active-low reset
//   en_i         : count while high; counter held at 0 while low
//   clr_i        : synchronous restart of the count
//   tick_o       : one-cycle pulse every CLK_DIV enabled cycles (CLK_DIV 2..255)
module ads_clk_div #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    tick_o  = en_i && !clr_i && (count_q == LAST);
    count_d = count_q + 8'd1;
    if (!en_i || clr_i || tick_o) count_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/ads7843_spi_ctrl.sv
// ads7843_spi_ctrl: Avalon-MM slave that runs one 24-DCLK ADS7843 conversion
// frame per command byte and returns the 12-bit result.
//   clk, reset_n                 : system clock, asynchronous active-low reset
//   chipselect, address, write_n,
//   writedata, read_n, readdata  : Avalon slave (readdata combinational on address)
//     addr 0 R/W cmd, addr 1 status {busy_sync, done, busy} / W bit1 clears done,
//     addr 2 R result, addr 3 IRQ control (only with ADS_PENIRQ_EN)
//   ads_cs_n, ads_dclk, ads_din  : registered touch-controller outputs
//   ads_dout, ads_busy           : touch-controller inputs, 2-FF synchronised
// Optional macro ADS_PENIRQ_EN adds ads_penirq_n input and irq output.
module ads7843_spi_ctrl
  import ads7843_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 25,
  parameter int unsigned FRAME_LEN = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        read_n,
  output logic [31:0] readdata,
  output logic        ads_cs_n,
  output logic        ads_dclk,
  output logic        ads_din,
  input  logic        ads_dout,
  input  logic        ads_busy
`ifdef ADS_PENIRQ_EN
  ,
  input  logic        ads_penirq_n,
  output logic        irq
`endif
);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [4:0]  bit_q, bit_d;
  logic [11:0] sh_q, sh_d;
  logic [11:0] result_q, result_d;
  logic        done_q, done_d;
  logic        cs_n_q, cs_n_d;
  logic        dclk_q, dclk_d;
  logic        din_q, din_d;
  logic        dout_s1_q, dout_s2_q;
  logic        busy_s1_q, busy_s2_q;
  logic        start, tick, wr, busy;
  logic [4:0]  n_edge;
  logic [7:0]  cmd_sh;
  logic        unused_bus;

  assign wr         = chipselect & ~write_n;
  assign busy       = (state_q != S_IDLE);
  assign unused_bus = ^{writedata[31:8], read_n};

  assign ads_cs_n = cs_n_q;
  assign ads_dclk = dclk_q;
  assign ads_din  = din_q;

  ads_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (busy),
    .clr_i   (start),
    .tick_o  (tick)
  );

  // DCLK phase doubles as the edge selector: low means the next tick is a
  // rising edge. bit_q counts completed DCLK periods, so the edge number
  // (1-based) of the pending rising/falling edge is bit_q + 1.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    result_d = result_q;
    done_d   = done_q;
    cs_n_d   = cs_n_q;
    dclk_d   = dclk_q;
    din_d    = din_q;
    start    = 1'b0;
    n_edge   = bit_q + 5'd1;
    cmd_sh   = cmd_q << n_edge;

    // Clear first so that a frame completing in the same cycle wins.
    if (wr && (address == ADDR_STAT) && writedata[STAT_DONE]) done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr && (address == ADDR_CMD)) begin
          cmd_d   = writedata[7:0];
          done_d  = 1'b0;
          cs_n_d  = 1'b0;
          din_d   = writedata[7];
          bit_d   = '0;
          sh_d    = '0;
          start   = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (tick) begin
          if (!dclk_q) begin
            dclk_d = 1'b1;
            if (in_dout_window(n_edge)) sh_d = {sh_q[10:0], dout_s2_q};
          end else begin
            dclk_d = 1'b0;
            // Shifted-out command bits become zero once n_edge reaches 8.
            din_d  = cmd_sh[7];
            if (bit_q == 5'(FRAME_LEN - 1)) begin
              cs_n_d  = 1'b1;
              din_d   = 1'b0;
              state_d = S_HOLD;
            end else begin
              bit_d = n_edge;
            end
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          result_d = sh_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      dclk_q    <= 1'b0;
      din_q     <= 1'b0;
      dout_s1_q <= 1'b0;
      dout_s2_q <= 1'b0;
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      result_q  <= result_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
      dclk_q    <= dclk_d;
      din_q     <= din_d;
      dout_s1_q <= ads_dout;
      dout_s2_q <= dout_s1_q;
      busy_s1_q <= ads_busy;
      busy_s2_q <= busy_s1_q;
    end
  end

`ifdef ADS_PENIRQ_EN
  logic pen_s1_q, pen_s2_q, pen_prev_q;
  logic pen_pending_q, pen_pending_d;
  logic irq_en_q, irq_en_d;

  always_comb begin
    irq_en_d      = irq_en_q;
    pen_pending_d = pen_pending_q;
    if (wr && (address == ADDR_IRQ)) begin
      irq_en_d = writedata[IRQ_EN_BIT];
      if (writedata[IRQ_PEN_BIT]) pen_pending_d = 1'b0;
    end
    // Conversions disturb PENIRQ, so only edges seen while idle count.
    if (!busy && pen_prev_q && !pen_s2_q) pen_pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pen_s1_q      <= 1'b1;
      pen_s2_q      <= 1'b1;
      pen_prev_q    <= 1'b1;
      pen_pending_q <= 1'b0;
      irq_en_q      <= 1'b0;
    end else begin
      pen_s1_q      <= ads_penirq_n;
      pen_s2_q      <= pen_s1_q;
      pen_prev_q    <= pen_s2_q;
      pen_pending_q <= pen_pending_d;
      irq_en_q      <= irq_en_d;
    end
  end

  assign irq = irq_en_q & (pen_pending_q | done_q);
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CMD:  readdata[7:0] = cmd_q;
      ADDR_STAT: begin
        readdata[STAT_BUSY]      = busy;
        readdata[STAT_DONE]      = done_q;
        readdata[STAT_BUSY_SYNC] = busy_s2_q;
      end
      ADDR_DATA: readdata[11:0] = result_q;
`ifdef ADS_PENIRQ_EN
      ADDR_IRQ: begin
        readdata[IRQ_EN_BIT]  = irq_en_q;
        readdata[IRQ_PEN_BIT] = pen_pending_q;
      end
`endif
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ads7843_spi_ctrl.sv
// tb_ads7843_spi_ctrl: self-checking bench for ads7843_spi_ctrl with a
// behavioural touch-controller model (returns dev_val on DOUT) and a pin
// monitor that counts DCLK pulses and collects the command bits seen on DIN.
module tb_ads7843_spi_ctrl;

  localparam int unsigned CLK_DIV    = 5;
  localparam int          FRAME_CLKS = 50 * 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        read_n;
  logic [31:0] readdata;
  logic        ads_cs_n, ads_dclk, ads_din;
  logic        ads_dout = 1'b0;
  logic        ads_busy;
`ifdef ADS_PENIRQ_EN
  logic        ads_penirq_n;
  logic        irq;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;

  int          rise_cnt = 0, fall_cnt = 0, frame_cnt = 0, cs_violations = 0;
  logic [7:0]  din_bits = '0;
  logic [11:0] dev_val = '0;
  logic [11:0] last_result = '0;
  logic        prev_cs = 1'b1, prev_dclk = 1'b0;

  ads7843_spi_ctrl #(.CLK_DIV(CLK_DIV), .FRAME_LEN(24)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .read_n     (read_n),
    .readdata   (readdata),
    .ads_cs_n   (ads_cs_n),
    .ads_dclk   (ads_dclk),
    .ads_din    (ads_din),
    .ads_dout   (ads_dout),
    .ads_busy   (ads_busy)
`ifdef ADS_PENIRQ_EN
    ,
    .ads_penirq_n (ads_penirq_n),
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;

  // Pin monitor and device model: the device shifts dev_val out MSB first so
  // that rising edges 10..21 see bits 11..0; DOUT changes after falling edges.
  always @(posedge clk) begin
    #1;
    if (prev_cs && !ads_cs_n) begin
      rise_cnt  = 0;
      fall_cnt  = 0;
      din_bits  = '0;
      ads_dout  = 1'b0;
      frame_cnt = frame_cnt + 1;
    end
    if (!prev_dclk && ads_dclk) begin
      rise_cnt = rise_cnt + 1;
      if (ads_cs_n) cs_violations = cs_violations + 1;
      if (rise_cnt <= 8) din_bits = {din_bits[6:0], ads_din};
    end
    if (prev_dclk && !ads_dclk) begin
      fall_cnt = fall_cnt + 1;
      if (fall_cnt >= 9 && fall_cnt <= 20) ads_dout = dev_val[20 - fall_cnt];
      else                                 ads_dout = 1'b0;
    end
    prev_cs   = ads_cs_n;
    prev_dclk = ads_dclk;
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; address = a; writedata = d; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; address = a; read_n = 1'b0;
    #1 d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  // Returns the number of clocks after the write until done reads 1, or 0 on timeout.
  task automatic wait_done(output int cyc);
    logic [31:0] d;
    cyc = 0;
    for (int i = 1; i <= 1000; i++) begin
      bus_read(2'd1, d);
      if (d[1]) begin cyc = i; break; end
    end
  endtask

  task automatic run_frame(input logic [7:0] c, input logic [11:0] v);
    int          lat;
    int          f0;
    logic [31:0] d;
    dev_val = v;
    f0 = frame_cnt;
    bus_write(2'd0, {24'd0, c});
    wait_done(lat);
    n_tests++;
    if (lat < FRAME_CLKS - 1 || lat > FRAME_CLKS + 1) begin
      n_fail++; $display("FAIL frame_latency cmd=%02h: got %0d clks expected %0d+-1", c, lat, FRAME_CLKS);
    end
    n_tests++;
    if (rise_cnt !== 24) begin
      n_fail++; $display("FAIL dclk_pulses cmd=%02h: got %0d expected 24", c, rise_cnt);
    end
    n_tests++;
    if (din_bits !== c) begin
      n_fail++; $display("FAIL din_bits: got %02h expected %02h", din_bits, c);
    end
    n_tests++;
    if (frame_cnt !== f0 + 1) begin
      n_fail++; $display("FAIL frame_count cmd=%02h: got %0d expected %0d", c, frame_cnt, f0 + 1);
    end
    bus_read(2'd2, d);
    n_tests++;
    if (d !== {20'd0, v}) begin
      n_fail++; $display("FAIL result cmd=%02h: got %08h expected %08h", c, d, {20'd0, v});
    end
    bus_read(2'd0, d);
    n_tests++;
    if (d !== {24'd0, c}) begin
      n_fail++; $display("FAIL cmd_readback: got %08h expected %08h", d, {24'd0, c});
    end
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'h2) begin
      n_fail++; $display("FAIL status_after_frame: got %08h expected 00000002", d);
    end
    last_result = v;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_tests++;
    if ({ads_cs_n, ads_dclk, ads_din} !== 3'b100) begin
      n_fail++; $display("FAIL reset_pins: got %b expected 100", {ads_cs_n, ads_dclk, ads_din});
    end
    @(negedge clk) reset_n = 1'b1;
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %08h expected 00000000", d); end
    bus_read(2'd2, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %08h expected 00000000", d); end
    bus_read(2'd0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_cmd: got %08h expected 00000000", d); end
  endtask

  task automatic test_busy_status();
    logic [31:0] d;
    ads_busy = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL busy_sync_high: got %08h expected 00000004", d); end
    ads_busy = 1'b0;
    repeat (3) @(negedge clk);
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL busy_sync_low: got %08h expected 00000000", d); end
  endtask

  task automatic test_frames();
    run_frame(8'h90, 12'hA5C);
    for (int k = 0; k < 5; k++) run_frame(8'($urandom), 12'($urandom));
  endtask

  task automatic test_write_while_busy();
    logic [31:0] d;
    logic [11:0] v;
    int          lat;
    int          f0;
    v = 12'($urandom);
    dev_val = v;
    f0 = frame_cnt;
    bus_write(2'd0, 32'h90);
    repeat (100) @(negedge clk);
    bus_write(2'd0, 32'hD0);
    bus_read(2'd0, d);
    n_tests++;
    if (d !== 32'h90) begin n_fail++; $display("FAIL busy_write_cmd: got %08h expected 00000090", d); end
    bus_read(2'd2, d);
    n_tests++;
    if (d !== {20'd0, last_result}) begin
      n_fail++; $display("FAIL midframe_result: got %08h expected %08h", d, {20'd0, last_result});
    end
    wait_done(lat);
    n_tests++;
    if (lat == 0) begin n_fail++; $display("FAIL busy_write_done: got timeout expected done"); end
    n_tests++;
    if (din_bits !== 8'h90) begin n_fail++; $display("FAIL busy_write_din: got %02h expected 90", din_bits); end
    bus_read(2'd2, d);
    n_tests++;
    if (d !== {20'd0, v}) begin n_fail++; $display("FAIL busy_write_result: got %08h expected %08h", d, {20'd0, v}); end
    repeat (30) @(negedge clk);
    n_tests++;
    if (frame_cnt !== f0 + 1) begin n_fail++; $display("FAIL busy_write_frames: got %0d expected %0d", frame_cnt - f0, 1); end
    last_result = v;
  endtask

  task automatic test_clear_done();
    logic [31:0] d;
    bus_write(2'd1, 32'h2);
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL clear_done: got %08h expected 00000000", d); end
    bus_read(2'd2, d);
    n_tests++;
    if (d !== {20'd0, last_result}) begin
      n_fail++; $display("FAIL clear_keeps_result: got %08h expected %08h", d, {20'd0, last_result});
    end
  endtask

  // Writes land on the clock edge at which the frame completes (write + 250 clks).
  task automatic test_end_collisions();
    logic [31:0] d;
    logic [7:0]  c;
    int          f0;
    dev_val = 12'($urandom);
    bus_write(2'd0, 32'h90);
    repeat (FRAME_CLKS - 2) @(negedge clk);
    bus_write(2'd1, 32'h2);
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL clear_vs_set_done: got %08h expected 00000002", d); end
    last_result = dev_val;

    bus_write(2'd1, 32'h2);
    c = 8'($urandom) | 8'h80;
    dev_val = 12'($urandom);
    f0 = frame_cnt;
    bus_write(2'd0, {24'd0, c});
    repeat (FRAME_CLKS - 2) @(negedge clk);
    bus_write(2'd0, 32'h55);
    repeat (20) @(negedge clk);
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL end_write_status: got %08h expected 00000002", d); end
    bus_read(2'd0, d);
    n_tests++;
    if (d !== {24'd0, c}) begin n_fail++; $display("FAIL end_write_cmd: got %08h expected %08h", d, {24'd0, c}); end
    n_tests++;
    if (frame_cnt !== f0 + 1) begin n_fail++; $display("FAIL end_write_frames: got %0d expected 1", frame_cnt - f0); end
    last_result = dev_val;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    bit          hit;
    dev_val = 12'($urandom) | 12'h801;
    bus_write(2'd0, 32'h90);
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rise_cnt == 12) begin hit = 1'b1; break; end
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL reach_pulse12: got timeout expected pulse 12"); end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({ads_cs_n, ads_dclk, ads_din} !== 3'b100) begin
      n_fail++; $display("FAIL async_reset_pins: got %b expected 100", {ads_cs_n, ads_dclk, ads_din});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // Reset clears the stored result; the aborted frame must not deposit anything.
    bus_read(2'd2, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_result: got %08h expected 00000000", d); end
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_status: got %08h expected 00000000", d); end
    repeat (FRAME_CLKS) @(negedge clk);
    n_tests++;
    if (cs_violations !== 0) begin n_fail++; $display("FAIL dclk_while_cs_high: got %0d expected 0", cs_violations); end
  endtask

`ifdef ADS_PENIRQ_EN
  task automatic test_penirq();
    logic [31:0] d;
    bit          seen;
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL irq_en_readback: got %08h expected 00000001", d); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b expected 0", irq); end
    @(negedge clk) ads_penirq_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) begin seen = 1'b1; break; end
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL pen_irq: got 0 expected 1 within 3 clks"); end
    bus_read(2'd3, d);
    n_tests++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL pen_pending_read: got %08h expected 00000003", d); end
    bus_write(2'd3, 32'h3);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", irq); end
    ads_penirq_n = 1'b1;
  endtask
`else
  task automatic test_irq_absent();
    logic [31:0] d;
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL addr3_reads_zero: got %08h expected 00000000", d); end
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    address    = 2'd0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    writedata  = '0;
    ads_busy   = 1'b0;
`ifdef ADS_PENIRQ_EN
    ads_penirq_n = 1'b1;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    test_busy_status();
    test_frames();
    test_write_while_busy();
    test_clear_done();
    test_end_collisions();
    test_reset_mid_frame();
`ifdef ADS_PENIRQ_EN
    test_penirq();
`else
    test_irq_absent();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
